axis_msg_parser_p: RTL and testbench

Parametrised AXI-Stream message parser, successor to `msg_parser`. It accepts length-prefixed message packets on a slave AXI-Stream port of configurable width and extracts each message into a wide output register. It adds output backpressure, packet-level error detection with drain-to-`tlast` recovery, and optional statistics counters. It sits between the ingress stream and downstream message consumers.

---
 rtl/axis_msg_parser_p.sv | 252 +++++++++++++++++++++++++
 tb/tb_axis_msg_parser_p.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_msg_parser_p.sv
// Length-prefixed AXI-Stream message parser with output backpressure and drain-to-tlast error recovery.
// Define AXIS_MSG_PARSER_STATS_EN to add the stat_msgs/stat_errs saturating counters.
module axis_msg_parser_p #(
   parameter int TDATA_WIDTH   = 64,
   parameter int MAX_MSG_BYTES = 32,
   parameter int MIN_MSG_BYTES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [TDATA_WIDTH-1:0]     s_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   s_tkeep,
   input  logic                       s_tlast,
   input  logic                       s_tuser,
   output logic                       msg_valid,
   input  logic                       msg_ready,
   output logic [15:0]                msg_length,
   output logic [8*MAX_MSG_BYTES-1:0] msg_data,
   output logic                       msg_error
`ifdef AXIS_MSG_PARSER_STATS_EN
   ,
   output logic [31:0]                stat_msgs,
   output logic [31:0]                stat_errs
`endif
);

   localparam int NB = TDATA_WIDTH / 8;
   localparam int PW = $clog2(NB);
   localparam logic [15:0] MIN_L = 16'(MIN_MSG_BYTES);
   localparam logic [15:0] MAX_L = 16'(MAX_MSG_BYTES);
   localparam logic [PW:0] ONE_PC = 1;

   typedef enum logic [2:0] {CNT_LO, CNT_HI, LEN_LO, LEN_HI, PAYLOAD, EMIT, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic                       rdy_q;
   logic                       buf_vld_q, buf_vld_d;
   logic [TDATA_WIDTH-1:0]     buf_data_q, buf_data_d;
   logic [PW-1:0]              buf_kmax_q, buf_kmax_d;
   logic                       buf_last_q, buf_last_d;
   logic                       buf_err_q, buf_err_d;
   logic [PW-1:0]              ptr_q, ptr_d;
   logic [7:0]                 lo_q, lo_d;
   logic [15:0]                rem_q, rem_d;
   logic [15:0]                len_q, len_d;
   logic [15:0]                idx_q, idx_d;
   logic                       ended_q, ended_d;
   logic [15:0]                msg_length_q, msg_length_d;
   logic [8*MAX_MSG_BYTES-1:0] msg_data_q, msg_data_d;
   logic                       err_q, err_d;

   logic       accept, keep_ok, last_byte, end_pkt;
   logic       consume, flush, bad, fin;
   logic [7:0] cur_byte;
   logic [15:0] word;
   logic [PW:0] pc, pc_m1;

   assign s_tready   = rdy_q && !buf_vld_q;
   assign accept     = s_tvalid && s_tready;
   assign msg_valid  = (state_q == EMIT);
   assign msg_length = msg_length_q;
   assign msg_data   = msg_data_q;
   assign msg_error  = err_q;

   assign keep_ok   = (s_tkeep != '0) && ((s_tkeep & (s_tkeep + NB'(1))) == '0);
   assign last_byte = (ptr_q == buf_kmax_q);
   assign end_pkt   = last_byte && buf_last_q;
   assign word      = {cur_byte, lo_q};
   assign pc_m1     = pc - ONE_PC;

   always_comb begin
      pc = '0;
      for (int unsigned i = 0; i < NB; i++) pc = pc + {{PW{1'b0}}, s_tkeep[i]};
      cur_byte = '0;
      for (int unsigned i = 0; i < NB; i++)
         if (ptr_q == PW'(i)) cur_byte = buf_data_q[8*i +: 8];
   end

   always_comb begin
      state_d      = state_q;
      buf_vld_d    = buf_vld_q;
      buf_data_d   = buf_data_q;
      buf_kmax_d   = buf_kmax_q;
      buf_last_d   = buf_last_q;
      buf_err_d    = buf_err_q;
      ptr_d        = ptr_q;
      lo_d         = lo_q;
      rem_d        = rem_q;
      len_d        = len_q;
      idx_d        = idx_q;
      ended_d      = ended_q;
      msg_length_d = msg_length_q;
      msg_data_d   = msg_data_q;
      err_d        = 1'b0;
      consume      = 1'b0;
      flush        = 1'b0;
      bad          = 1'b0;
      fin          = 1'b0;

      if (buf_vld_q) begin
         case (state_q)
            EMIT: ;
            DRAIN: begin
               flush = 1'b1;
               if (buf_last_q) state_d = CNT_LO;
            end
            default: begin
               if (buf_err_q) begin
                  flush   = 1'b1;
                  err_d   = 1'b1;
                  state_d = buf_last_q ? CNT_LO : DRAIN;
               end else begin
                  consume = 1'b1;
                  ended_d = end_pkt;
                  case (state_q)
                     CNT_LO: begin
                        lo_d    = cur_byte;
                        state_d = CNT_HI;
                     end
                     CNT_HI: begin
                        rem_d   = word;
                        bad     = (word == '0);
                        state_d = LEN_LO;
                     end
                     LEN_LO: begin
                        lo_d    = cur_byte;
                        state_d = LEN_HI;
                     end
                     LEN_HI: begin
                        len_d = word;
                        bad   = (word < MIN_L) || (word > MAX_L);
                        if (!bad) begin
                           msg_length_d = word;
                           msg_data_d   = '0;
                           idx_d        = '0;
                           if (word == '0) begin
                              state_d = EMIT;
                              fin     = (rem_q == 16'd1);
                           end else begin
                              state_d = PAYLOAD;
                           end
                        end
                     end
                     PAYLOAD: begin
                        for (int unsigned i = 0; i < MAX_MSG_BYTES; i++)
                           if (idx_q == 16'(i)) msg_data_d[8*i +: 8] = cur_byte;
                        idx_d = idx_q + 16'd1;
                        if (idx_q + 16'd1 == len_q) begin
                           state_d = EMIT;
                           fin     = (rem_q == 16'd1);
                        end
                     end
                     default: ;
                  endcase
                  // tlast is only legal on the final payload byte of the final record
                  if (bad || (end_pkt && !fin)) begin
                     err_d   = 1'b1;
                     state_d = end_pkt ? CNT_LO : DRAIN;
                  end
               end
            end
         endcase
      end

      if (consume) begin
         if (last_byte) buf_vld_d = 1'b0;
         else           ptr_d     = ptr_q + PW'(1);
      end
      if (flush) buf_vld_d = 1'b0;

      // Overrun shows up after the final message is handed over: the packet has not yet seen tlast
      if (state_q == EMIT && msg_ready) begin
         rem_d = rem_q - 16'd1;
         if (rem_q == 16'd1) begin
            if (ended_q) begin
               state_d = CNT_LO;
            end else begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         end else begin
            state_d = LEN_LO;
         end
      end

      if (accept) begin
         buf_vld_d  = 1'b1;
         buf_data_d = s_tdata;
         buf_kmax_d = pc_m1[PW-1:0];
         buf_last_d = s_tlast;
         buf_err_d  = s_tuser || !keep_ok;
         ptr_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= CNT_LO;
         rdy_q        <= 1'b0;
         buf_vld_q    <= 1'b0;
         buf_data_q   <= '0;
         buf_kmax_q   <= '0;
         buf_last_q   <= 1'b0;
         buf_err_q    <= 1'b0;
         ptr_q        <= '0;
         lo_q         <= '0;
         rem_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         ended_q      <= 1'b0;
         msg_length_q <= '0;
         msg_data_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rdy_q        <= 1'b1;
         buf_vld_q    <= buf_vld_d;
         buf_data_q   <= buf_data_d;
         buf_kmax_q   <= buf_kmax_d;
         buf_last_q   <= buf_last_d;
         buf_err_q    <= buf_err_d;
         ptr_q        <= ptr_d;
         lo_q         <= lo_d;
         rem_q        <= rem_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         ended_q      <= ended_d;
         msg_length_q <= msg_length_d;
         msg_data_q   <= msg_data_d;
         err_q        <= err_d;
      end
   end

`ifdef AXIS_MSG_PARSER_STATS_EN
   logic [31:0] stat_msgs_q, stat_errs_q;

   assign stat_msgs = stat_msgs_q;
   assign stat_errs = stat_errs_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_msgs_q <= '0;
         stat_errs_q <= '0;
      end else begin
         if (msg_valid && msg_ready && stat_msgs_q != '1) stat_msgs_q <= stat_msgs_q + 32'd1;
         if (err_q && stat_errs_q != '1) stat_errs_q <= stat_errs_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_msg_parser_p.sv
// Directed self-checking bench for axis_msg_parser_p (64-bit stream, 8..32 byte messages).
module tb_axis_msg_parser_p;

   localparam int TW = 64;

   localparam logic [255:0] E1  = 256'h630d658d_abcddcef;
   localparam logic [255:0] E2A = 256'ha5b0_03889560_84130858_045de506;
   localparam logic [255:0] E2B = 256'hd845a30c_85468052;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_tvalid, s_tready, s_tlast, s_tuser;
   logic [TW-1:0] s_tdata;
   logic [7:0]    s_tkeep;
   logic          msg_valid, msg_ready, msg_error;
   logic [15:0]   msg_length;
   logic [255:0]  msg_data;
`ifdef AXIS_MSG_PARSER_STATS_EN
   logic [31:0]   stat_msgs, stat_errs;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0]  q_len[$];
   logic [255:0] q_dat[$];
   int           n_err, n_both;

   always #5 clk = ~clk;

   axis_msg_parser_p #(
      .TDATA_WIDTH  (TW),
      .MAX_MSG_BYTES(32),
      .MIN_MSG_BYTES(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tdata   (s_tdata),
      .s_tkeep   (s_tkeep),
      .s_tlast   (s_tlast),
      .s_tuser   (s_tuser),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .msg_length(msg_length),
      .msg_data  (msg_data),
      .msg_error (msg_error)
`ifdef AXIS_MSG_PARSER_STATS_EN
      ,
      .stat_msgs (stat_msgs),
      .stat_errs (stat_errs)
`endif
   );

   // Record completed handshakes and error pulses between rising edges
   always @(negedge clk) begin
      if (rst) begin
         if (msg_valid && msg_ready) begin
            q_len.push_back(msg_length);
            q_dat.push_back(msg_data);
         end
         if (msg_error) n_err++;
         if (msg_error && msg_valid) n_both++;
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
      int n = 0;
      @(negedge clk);
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      while (s_tready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (s_tready !== 1'b1) begin
         errors++;
         $display("FAIL beat_accept: s_tready=%b required 1", s_tready);
      end
      @(posedge clk);
      #1 s_tvalid = 1'b0;
   endtask

   task automatic send_single();
      send_beat(64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h00000000_630d658d, 8'h0F, 1'b1, 1'b0);
   endtask

   task automatic send_pkt2(input logic u1);
      send_beat(64'h045de506_000e0002, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h03889560_84130858, 8'hFF, 1'b0, u1);
      send_beat(64'h85468052_0008a5b0, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h00000000_d845a30c, 8'h0F, 1'b1, 1'b0);
   endtask

   task automatic settle();
      repeat (30) @(negedge clk);
   endtask

   task automatic clear_mon();
      q_len.delete();
      q_dat.delete();
      n_err  = 0;
      n_both = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; msg_ready = 1'b1;
      repeat (2) @(negedge clk);
      clear_mon();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({s_tready, msg_valid, msg_error} !== 3'b000 || msg_length !== 16'd0 || msg_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b vld=%b err=%b len=%h data=%h required all 0",
                  s_tready, msg_valid, msg_error, msg_length, msg_data);
      end
      @(negedge clk);
      clear_mon();
      rst = 1'b1;
      #1;
      checks++;
      if (s_tready !== 1'b0) begin
         errors++;
         $display("FAIL tready_before_edge: s_tready=%b required 0", s_tready);
      end
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin
         errors++;
         $display("FAIL tready_first_edge: s_tready=%b required 1", s_tready);
      end
   endtask

   task automatic test_single();
      do_reset();
      send_beat(64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h00000000_630d658d, 8'h0F, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if (msg_valid !== 1'b0 || s_tready !== 1'b0) begin
         errors++;
         $display("FAIL single_early: vld=%b rdy=%b required 0 0", msg_valid, s_tready);
      end
      @(negedge clk);
      checks++;
      if (msg_valid !== 1'b1 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: vld=%b rdy=%b required 1 1", msg_valid, s_tready);
      end
      settle();
      checks++;
      if (q_len.size() != 1 || n_err != 0) begin
         errors++;
         $display("FAIL single_count: msgs=%0d errs=%0d required 1 0", q_len.size(), n_err);
      end else begin
         checks++;
         if (q_len[0] !== 16'd8 || q_dat[0] !== E1) begin
            errors++;
            $display("FAIL single_msg: len=%0d data=%h required 8 %h", q_len[0], q_dat[0], E1);
         end
      end
   endtask

   task automatic test_two_msgs();
      do_reset();
      send_pkt2(1'b0);
      settle();
      checks++;
      if (q_len.size() != 2 || n_err != 0) begin
         errors++;
         $display("FAIL two_count: msgs=%0d errs=%0d required 2 0", q_len.size(), n_err);
      end else begin
         checks++;
         if (q_len[0] !== 16'd14 || q_dat[0] !== E2A) begin
            errors++;
            $display("FAIL two_msg1: len=%0d data=%h required 14 %h", q_len[0], q_dat[0], E2A);
         end
         checks++;
         if (q_len[1] !== 16'd8 || q_dat[1] !== E2B) begin
            errors++;
            $display("FAIL two_msg2: len=%0d data=%h required 8 %h", q_len[1], q_dat[1], E2B);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] held;
      logic [15:0]  hlen;
      int n;
      do_reset();
      msg_ready = 1'b0;
      fork
         send_pkt2(1'b0);
         begin
            n = 0;
            while (msg_valid !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if (msg_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_valid: msg_valid=%b required 1", msg_valid);
            end
            held = msg_data;
            hlen = msg_length;
            checks++;
            if (held !== E2A || hlen !== 16'd14) begin
               errors++;
               $display("FAIL bp_first: len=%0d data=%h required 14 %h", hlen, held, E2A);
            end
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               checks++;
               if (msg_valid !== 1'b1 || msg_data !== held || msg_length !== hlen || s_tready !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_hold: vld=%b rdy=%b len=%0d data=%h required 1 0 14 %h",
                           msg_valid, s_tready, msg_length, msg_data, held);
               end
            end
            @(posedge clk);
            #1 msg_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (msg_valid !== 1'b0) begin
               errors++;
               $display("FAIL bp_drop: msg_valid=%b required 0", msg_valid);
            end
         end
      join
      settle();
      checks++;
      if (q_len.size() != 2 || n_err != 0) begin
         errors++;
         $display("FAIL bp_count: msgs=%0d errs=%0d required 2 0", q_len.size(), n_err);
      end else begin
         checks++;
         if (q_dat[0] !== E2A || q_len[1] !== 16'd8 || q_dat[1] !== E2B) begin
            errors++;
            $display("FAIL bp_msgs: m1=%h m2len=%0d m2=%h required %h 8 %h",
                     q_dat[0], q_len[1], q_dat[1], E2A, E2B);
         end
      end
   endtask

   task automatic test_len_violation();
      do_reset();
      send_beat(64'h11223344_00040001, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h55667788_99aabbcc, 8'hFF, 1'b1, 1'b0);
      settle();
      checks++;
      if (n_err != 1 || q_len.size() != 0) begin
         errors++;
         $display("FAIL len_err: errs=%0d msgs=%0d required 1 0", n_err, q_len.size());
      end
      send_single();
      settle();
      checks++;
      if (q_len.size() != 1 || n_err != 1) begin
         errors++;
         $display("FAIL len_recover_count: msgs=%0d errs=%0d required 1 1", q_len.size(), n_err);
      end else begin
         checks++;
         if (q_dat[0] !== E1 || q_len[0] !== 16'd8) begin
            errors++;
            $display("FAIL len_recover_msg: len=%0d data=%h required 8 %h", q_len[0], q_dat[0], E1);
         end
      end
   endtask

   task automatic test_tuser();
      do_reset();
      send_pkt2(1'b1);
      settle();
      checks++;
      if (n_err != 1 || q_len.size() != 0) begin
         errors++;
         $display("FAIL tuser_err: errs=%0d msgs=%0d required 1 0", n_err, q_len.size());
      end
      send_single();
      settle();
      checks++;
      if (q_len.size() != 1 || q_dat[0] !== E1) begin
         errors++;
         $display("FAIL tuser_recover: msgs=%0d required 1 with data %h", q_len.size(), E1);
      end
`ifdef AXIS_MSG_PARSER_STATS_EN
      checks++;
      if (stat_errs !== 32'd1 || stat_msgs !== 32'd1) begin
         errors++;
         $display("FAIL tuser_stats: errs=%0d msgs=%0d required 1 1", stat_errs, stat_msgs);
      end
`endif
   endtask

   task automatic test_framing_errors();
      // count == 0
      do_reset();
      send_beat(64'h0, 8'h03, 1'b1, 1'b0);
      settle();
      checks++;
      if (n_err != 1 || q_len.size() != 0) begin
         errors++;
         $display("FAIL count_zero: errs=%0d msgs=%0d required 1 0", n_err, q_len.size());
      end
      // truncated in the middle of the payload
      do_reset();
      send_beat(64'habcddcef_00080001, 8'hFF, 1'b1, 1'b0);
      settle();
      checks++;
      if (n_err != 1 || q_len.size() != 0) begin
         errors++;
         $display("FAIL truncation: errs=%0d msgs=%0d required 1 0", n_err, q_len.size());
      end
      // extra bytes after the final record: message kept, then error
      do_reset();
      send_beat(64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
      send_beat(64'h11111111_630d658d, 8'hFF, 1'b1, 1'b0);
      settle();
      checks++;
      if (n_err != 1 || q_len.size() != 1 || n_both != 0) begin
         errors++;
         $display("FAIL overrun: errs=%0d msgs=%0d overlap=%0d required 1 1 0", n_err, q_len.size(), n_both);
      end else begin
         checks++;
         if (q_dat[0] !== E1) begin
            errors++;
            $display("FAIL overrun_msg: data=%h required %h", q_dat[0], E1);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_beat(64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      checks++;
      if (msg_length !== 16'd8) begin
         errors++;
         $display("FAIL mid_length: msg_length=%0d required 8", msg_length);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({s_tready, msg_valid, msg_error} !== 3'b000 || msg_length !== 16'd0 || msg_data !== '0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b vld=%b err=%b len=%h data=%h required all 0",
                  s_tready, msg_valid, msg_error, msg_length, msg_data);
      end
      @(negedge clk);
      clear_mon();
      rst = 1'b1;
      send_single();
      settle();
      checks++;
      if (q_len.size() != 1 || n_err != 0) begin
         errors++;
         $display("FAIL mid_count: msgs=%0d errs=%0d required 1 0", q_len.size(), n_err);
      end else begin
         checks++;
         if (q_dat[0] !== E1 || q_len[0] !== 16'd8) begin
            errors++;
            $display("FAIL mid_msg: len=%0d data=%h required 8 %h", q_len[0], q_dat[0], E1);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
      msg_ready = 1'b1;
      test_reset();
      test_single();
      test_two_msgs();
      test_backpressure();
      test_len_violation();
      test_tuser();
      test_framing_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
